// File: rtl/reg_file_pkg.sv
// Shared processor package: datapath widths and write-back buffer state encoding,
// common to the register file, ALU and control unit.
package reg_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/reg_file.sv
// Register file with two combinational read ports and one write port fronted by
// a one-entry write-back buffer that parks a write while memory stalls.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              PENDING
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  wb_state_t         state, state_next;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              buf_load;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    waddr      = INADDRESS;
    wdata      = IN;
    buf_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (WRITE) begin
          if (BUSYWAIT) begin
            buf_load   = 1'b1;
            state_next = HOLD;
          end else begin
            we = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!BUSYWAIT) begin
          // A fresh write at the release edge supersedes the parked one.
          we         = 1'b1;
          state_next = IDLE;
          if (!WRITE) begin
            waddr = buf_addr;
            wdata = buf_data;
          end
        end else if (WRITE) begin
          buf_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the array is reset asynchronously along with the control state, because
  // reads must show zero the moment RESET_N falls, not after the next clock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      buf_addr <= '0;
      buf_data <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      if (buf_load) begin
        buf_addr <= INADDRESS;
        buf_data <= IN;
      end
      if (we) regs[waddr] <= wdata;
    end
  end

  // No bypass: a write becomes visible only once the array itself has changed.
  assign OUT1    = regs[OUT1ADDRESS];
  assign OUT2    = regs[OUT2ADDRESS];
  assign PENDING = (state == HOLD);

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 8: register and port data width; matches the ALU operand/result width.
REQ-002 Parameter ADDR_W, default 3: register address width; depth = 2**ADDR_W (8 registers).
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 IN  input  DATA_W  write data, driven from the ALU result.
REQ-006 INADDRESS  input  ADDR_W  write register index.
REQ-007 WRITE  input  1  write request, sampled at the rising edge of CLK.
REQ-008 BUSYWAIT  input  1  memory stall; while high, no register is updated.
REQ-009 OUT1ADDRESS  input  ADDR_W  read port 1 index.
REQ-010 OUT2ADDRESS  input  ADDR_W  read port 2 index.
REQ-011 OUT1  output  DATA_W  read port 1 data, feeds ALU OPERAND1.
REQ-012 OUT2  output  DATA_W  read port 2 data, feeds ALU OPERAND2 (via the negate/immediate mux).
REQ-013 PENDING  output  1  high while a stalled write is held in the write-back buffer.

Function
REQ-014 Reads shall be combinational from the register array; OUTn = reg[OUTnADDRESS] with zero added clock latency.
REQ-015 There shall be no read bypass: a write committed at edge N is visible on OUT1/OUT2 only after edge N.
REQ-016 WRITE=1 with BUSYWAIT=0 and PENDING=0 at an edge shall write IN into reg[INADDRESS] at that edge (1-cycle write latency).
REQ-017 WRITE=1 with BUSYWAIT=1 at an edge shall capture {INADDRESS, IN} into a one-entry buffer, set PENDING=1, and leave the array unchanged.
REQ-018 Buffer FSM states: IDLE (PENDING=0) and HOLD (PENDING=1).
REQ-019 IDLE->HOLD on WRITE&BUSYWAIT; HOLD->IDLE on the first edge with BUSYWAIT=0, at which edge the buffered entry is committed to the array.
REQ-020 In HOLD with WRITE=1 and BUSYWAIT=1, the buffer shall be overwritten by the new {INADDRESS, IN} (newest wins); the state remains HOLD.
REQ-021 In HOLD with WRITE=1 and BUSYWAIT=0 at the same edge, the new write shall commit and the buffered entry shall be discarded (newest wins; same or different address).
REQ-022 WRITE=0 in IDLE shall leave all state unchanged regardless of BUSYWAIT.
REQ-023 Each edge shall commit at most one register write.
REQ-024 All addresses 0..2**ADDR_W-1 are writable; there is no hard-wired zero register.

Reset
REQ-025 RESET_N low shall immediately, without waiting for CLK, clear every register to 0, clear the buffer, and force IDLE (PENDING=0).
REQ-026 While RESET_N is low, OUT1/OUT2 shall read 0 and WRITE shall be ignored.
REQ-027 A stalled write held when RESET_N asserts shall be lost and never committed.
REQ-028 Deassertion of RESET_N shall take effect from the first rising edge of CLK at which RESET_N is sampled high.

Structure
REQ-029 DATA_W/ADDR_W defaults and the IDLE/HOLD state encoding shall reside in the shared processor package, also used by the ALU and the control unit.
REQ-030 The block shall be a single module with no sub-modules; the one-entry buffer is inline logic.

Verification
REQ-031 Reset, then write 8'h0F to r1 and 8'h0A to r2 (BUSYWAIT=0), read r1/r2 -> OUT1=0F, OUT2=0A one edge after each write; ALU ADD then gives 19.
REQ-032 Write 8'h55 to r3 with BUSYWAIT=1 for 3 cycles -> PENDING=1 for those cycles and r3 still reads 0; BUSYWAIT drops -> r3=55 after the next edge, PENDING=0.
REQ-033 In HOLD with buffered r4=11, write r4=22 with BUSYWAIT=1, then drop BUSYWAIT -> r4=22 and 11 is never observed.
REQ-034 In HOLD with buffered r5=AA, write r6=BB at the edge where BUSYWAIT=0 -> r6=BB, r5 unchanged (0), PENDING=0.
REQ-035 Fill r0..r7 with 8'h01..8'h08, assert RESET_N=0 mid-cycle with a held write -> all outputs 0 before the next edge, PENDING=0, and the held write is never committed.
REQ-036 Set OUT1ADDRESS=OUT2ADDRESS=INADDRESS=7 and write 8'hFF -> both ports show the old value until the edge and FF after it.
